// File: rtl/video_acc_pkg.sv
// Shared opcodes, FSM state type and instruction field helpers for the
// video accelerator instruction sequencer.
package video_acc_pkg;

  localparam logic [5:0] OP_NOP          = 6'd0;
  localparam logic [5:0] OP_LOAD_RD_FULL = 6'd2;
  localparam logic [5:0] OP_LOAD_WR_FULL = 6'd3;
  localparam logic [5:0] OP_LOAD_RD_LOW  = 6'd4;
  localparam logic [5:0] OP_LOAD_WR_LOW  = 6'd5;
  localparam int         META_END        = 8;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    LOAD_HI_RD = 3'd1,
    LOAD_HI_WR = 3'd2,
    ISSUE      = 3'd3,
    WAIT       = 3'd4
  } state_t;

  // Offsets and lengths are stored in 64-byte units in the instruction word.
  function automatic logic [12:0] f_src(input logic [31:0] w);
    return {w[12:6], 6'b0};
  endfunction

  function automatic logic [12:0] f_dst(input logic [31:0] w);
    return {w[19:13], 6'b0};
  endfunction

  function automatic logic [12:0] f_len(input logic [31:0] w);
    return {w[26:20], 6'b0};
  endfunction

endpackage

// File: rtl/video_inst_fifo.sv
// First-word-fall-through instruction FIFO with an exact occupancy count.
// A push while full is only accepted when a pop frees the slot in the same cycle.
module video_inst_fifo #(
  parameter int W  = 32,
  parameter int AW = 5
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_push,
  input  logic [W-1:0]  i_wdata,
  input  logic          i_pop,
  output logic [W-1:0]  o_rdata,
  output logic [AW:0]   o_count,
  output logic          o_ready,
  output logic          o_empty
);

  localparam int DEPTH = 1 << AW;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;

  logic w_full;
  logic w_empty;
  logic w_pop;
  logic w_push;

  assign w_full  = (r_count == (AW+1)'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_pop   = i_pop & ~w_empty;
  assign w_push  = i_push & (~w_full | w_pop);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wptr] <= i_wdata;
  end

  assign o_rdata = r_mem[r_rptr];
  assign o_count = r_count;
  assign o_ready = ~w_full;
  assign o_empty = w_empty;

endmodule

// File: rtl/video_acc_seq.sv
// Instruction sequencer: decodes base-address loads and data-movement words
// from the FIFO head and issues one read and one write mover command each.
module video_acc_seq
  import video_acc_pkg::*;
#(
  parameter int ADDR_WIDTH = 64,
  parameter int DEST_WIDTH = 3,
  parameter int N_FUN      = 3,
  parameter int FIFO_AW    = 5
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [31:0]           inst_data,
  input  logic                  inst_valid,
  output logic                  inst_ready,
  output logic [FIFO_AW:0]      inst_count,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [12:0]           rd_len,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic                  wr_valid,
  input  logic                  wr_ready,
  output logic [DEST_WIDTH-1:0] route_dest,
  output logic                  busy,
  output logic                  err,
  input  logic                  err_clr,
  output state_t                dbg_state
);

  logic [31:0]           w_head;
  logic                  w_empty;
  logic                  w_pop;
  logic [5:0]            w_op;
  logic                  w_is_mov;

  state_t                r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_base_rd, r_base_wr;
  logic [ADDR_WIDTH-1:0] r_rd_addr, r_wr_addr;
  logic [12:0]           r_rd_len;
  logic [DEST_WIDTH-1:0] r_route_dest;
  logic                  r_rd_valid, r_wr_valid, r_err;

  logic w_rd_v_nxt, w_wr_v_nxt;
  logic w_ld_rd_lo, w_ld_wr_lo, w_ld_rd_hi, w_ld_wr_hi;
  logic w_issue, w_set_err;

  video_inst_fifo #(.W(32), .AW(FIFO_AW)) u_fifo (
    .i_clk   (aclk),
    .i_rst_n (aresetn),
    .i_push  (inst_valid),
    .i_wdata (inst_data),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_count (inst_count),
    .o_ready (inst_ready),
    .o_empty (w_empty)
  );

  assign w_op     = w_head[5:0];
  assign w_is_mov = (w_op >= 6'(META_END)) && (w_op <= 6'(META_END + N_FUN));

  // Mover handshake: a command transfers on a cycle where valid and ready are
  // both high; valid then drops. ready=1 also means the mover is idle, which is
  // only trusted as completion once both commands have transferred (WAIT).
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_rd_v_nxt  = r_rd_valid;
    w_wr_v_nxt  = r_wr_valid;
    w_ld_rd_lo  = 1'b0;
    w_ld_wr_lo  = 1'b0;
    w_ld_rd_hi  = 1'b0;
    w_ld_wr_hi  = 1'b0;
    w_issue     = 1'b0;
    w_set_err   = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          if (w_op == OP_NOP) begin
            w_pop = 1'b1;
          end else if (w_op == OP_LOAD_RD_FULL || w_op == OP_LOAD_RD_LOW) begin
            w_pop      = 1'b1;
            w_ld_rd_lo = 1'b1;
            if (w_op == OP_LOAD_RD_FULL) w_state_nxt = LOAD_HI_RD;
          end else if (w_op == OP_LOAD_WR_FULL || w_op == OP_LOAD_WR_LOW) begin
            w_pop      = 1'b1;
            w_ld_wr_lo = 1'b1;
            if (w_op == OP_LOAD_WR_FULL) w_state_nxt = LOAD_HI_WR;
          end else if (w_is_mov) begin
            if (f_len(w_head) == '0) begin
              w_pop = 1'b1;
            end else begin
              w_issue     = 1'b1;
              w_rd_v_nxt  = 1'b1;
              w_wr_v_nxt  = 1'b1;
              w_state_nxt = ISSUE;
            end
          end else begin
            w_pop     = 1'b1;
            w_set_err = 1'b1;
          end
        end
      end
      LOAD_HI_RD, LOAD_HI_WR: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_ld_rd_hi  = (r_state == LOAD_HI_RD);
          w_ld_wr_hi  = (r_state == LOAD_HI_WR);
          w_state_nxt = IDLE;
        end
      end
      ISSUE: begin
        w_rd_v_nxt = r_rd_valid & ~rd_ready;
        w_wr_v_nxt = r_wr_valid & ~wr_ready;
        if (!w_rd_v_nxt && !w_wr_v_nxt) w_state_nxt = WAIT;
      end
      WAIT: begin
        if (rd_ready && wr_ready) begin
          w_pop       = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state      <= IDLE;
      r_base_rd    <= '0;
      r_base_wr    <= '0;
      r_rd_addr    <= '0;
      r_wr_addr    <= '0;
      r_rd_len     <= '0;
      r_route_dest <= '0;
      r_rd_valid   <= 1'b0;
      r_wr_valid   <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_rd_valid <= w_rd_v_nxt;
      r_wr_valid <= w_wr_v_nxt;
      if (w_ld_rd_lo) r_base_rd[31:6] <= w_head[31:6];
      if (w_ld_wr_lo) r_base_wr[31:6] <= w_head[31:6];
      if (w_ld_rd_hi) r_base_rd[ADDR_WIDTH-1:32] <= w_head[ADDR_WIDTH-33:0];
      if (w_ld_wr_hi) r_base_wr[ADDR_WIDTH-1:32] <= w_head[ADDR_WIDTH-33:0];
      if (w_issue) begin
        r_rd_addr    <= r_base_rd + ADDR_WIDTH'(f_src(w_head));
        r_wr_addr    <= r_base_wr + ADDR_WIDTH'(f_dst(w_head));
        r_rd_len     <= f_len(w_head);
        r_route_dest <= DEST_WIDTH'(w_op - 6'(META_END));
      end
      if (err_clr)        r_err <= 1'b0;
      else if (w_set_err) r_err <= 1'b1;
    end
  end

  assign rd_addr    = r_rd_addr;
  assign wr_addr    = r_wr_addr;
  assign rd_len     = r_rd_len;
  assign rd_valid   = r_rd_valid;
  assign wr_valid   = r_wr_valid;
  assign route_dest = r_route_dest;
  assign err        = r_err;
  assign busy       = (r_state != IDLE) || !w_empty;
  assign dbg_state  = r_state;

endmodule
